// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding,
// default idle line level and a counter-width helper.
package seq_pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic IDLE_LVL_DEFAULT = 1'b0;

  // Bits needed to hold max_val, never less than one so a zero-length gap still elaborates.
  function automatic int ctr_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= max_val) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_down_ctr.sv
// Loadable saturating down-counter with zero and one flags; used for the bit,
// repeat and gap counts of the pattern transmitter.
module seq_down_ctr
  import seq_pattern_tx_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a pattern word, shifts it out MSB-first
// one bit per clock and repeats it with an optional idle gap between copies.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int   DATA_W   = 8,
  parameter int   LEN_W    = 4,
  parameter int   REP_W    = 4,
  parameter int   GAP_CYC  = 2,
  parameter logic IDLE_LVL = IDLE_LVL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pat_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [REP_W-1:0]  rep_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int               GAP_W   = ctr_width(GAP_CYC);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

  state_t state, state_next;

  logic [DATA_W-1:0] pat_q, shift_q, shift_next, aligned_in;
  logic [LEN_W-1:0]  len_eff, len_m1, shamt, bit_load_val;

  logic accept, restart, step, enter_gap;
  logic bit_zero, bit_last, rep_zero, rep_last, gap_zero, gap_last;
  logic data_next, valid_next, idx_zero_next, last_next, done_next;

  // Patterns are left-aligned so the first bit to send always sits in the MSB.
  always_comb begin
    len_eff    = ((len_in == '0) || (len_in > MAX_LEN)) ? MAX_LEN : len_in;
    shamt      = MAX_LEN - len_eff;
    aligned_in = pat_in << shamt;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    restart    = 1'b0;
    step       = 1'b0;
    enter_gap  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!bit_zero) begin
          step = 1'b1;
        end else if (rep_zero) begin
          state_next = ST_IDLE;
        end else if (GAP_CYC == 0) begin
          restart = 1'b1;
        end else begin
          enter_gap  = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_last || gap_zero) begin
          restart    = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The repeat count drops on each restart, so a restart begins the last copy when it reads one.
  always_comb begin
    data_next     = IDLE_LVL;
    valid_next    = 1'b0;
    idx_zero_next = 1'b0;
    last_next     = 1'b0;
    shift_next    = shift_q;
    if (accept) begin
      data_next     = aligned_in[DATA_W-1];
      shift_next    = aligned_in << 1;
      valid_next    = 1'b1;
      idx_zero_next = (len_eff == LEN_W'(1));
      last_next     = (rep_in == '0);
    end else if (restart) begin
      data_next     = pat_q[DATA_W-1];
      shift_next    = pat_q << 1;
      valid_next    = 1'b1;
      idx_zero_next = (len_m1 == '0);
      last_next     = rep_last;
    end else if (step) begin
      data_next     = shift_q[DATA_W-1];
      shift_next    = shift_q << 1;
      valid_next    = 1'b1;
      idx_zero_next = bit_last;
      last_next     = rep_zero;
    end
    done_next = valid_next & idx_zero_next & last_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pat_q     <= '0;
      shift_q   <= '0;
      len_m1    <= '0;
      data_out  <= IDLE_LVL;
      out_valid <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      shift_q   <= shift_next;
      data_out  <= data_next;
      out_valid <= valid_next;
      done      <= done_next;
      in_ready  <= (state_next == ST_IDLE);
      busy      <= (state_next != ST_IDLE);
      if (accept) begin
        pat_q  <= aligned_in;
        len_m1 <= len_eff - LEN_W'(1);
      end
    end
  end

  assign bit_load_val = accept ? (len_eff - LEN_W'(1)) : len_m1;

  seq_down_ctr #(.W(LEN_W)) u_bit_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept | restart),
    .load_val (bit_load_val),
    .dec      (step),
    .zero     (bit_zero),
    .last     (bit_last)
  );

  seq_down_ctr #(.W(REP_W)) u_rep_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (rep_in),
    .dec      (restart),
    .zero     (rep_zero),
    .last     (rep_last)
  );

  seq_down_ctr #(.W(GAP_W)) u_gap_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (enter_gap),
    .load_val (GAP_W'(GAP_CYC)),
    .dec      ((state == ST_GAP) && !gap_last),
    .zero     (gap_zero),
    .last     (gap_last)
  );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: one instance with a two-cycle gap and
// one with back-to-back copies, expected bits and cycles queued at each accept.
module tb_seq_pattern_tx;

  typedef struct packed {
    logic data;
    logic done;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pat_in = '0;
  logic [3:0] len_in = '0;
  logic [3:0] rep_in = '0;
  logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic       in_ready0, data_out0, out_valid0, busy0, done0;
  logic       in_ready1, data_out1, out_valid1, busy1, done1;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  int   det_hits = 0;
  int   det_cnt = 0;
  logic [2:0] det_hist = '0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  seq_pattern_tx #(.GAP_CYC(2)) dut_gap (
    .clk(clk), .rst(rst), .pat_in(pat_in), .len_in(len_in), .rep_in(rep_in),
    .in_valid(in_valid0), .in_ready(in_ready0), .data_out(data_out0),
    .out_valid(out_valid0), .busy(busy0), .done(done0)
  );

  seq_pattern_tx #(.GAP_CYC(0)) dut_b2b (
    .clk(clk), .rst(rst), .pat_in(pat_in), .len_in(len_in), .rep_in(rep_in),
    .in_valid(in_valid1), .in_ready(in_ready1), .data_out(data_out1),
    .out_valid(out_valid1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic waitCycle(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // Drives one request, waits (bounded) for the handshake and queues the expected bit stream.
  task automatic applyStimulus(input int id, input logic [7:0] pat, input logic [3:0] len,
                               input logic [3:0] rep);
    int   l, gap, r;
    logic ok;
    exp_t e;
    @(negedge clk);
    pat_in = pat;
    len_in = len;
    rep_in = rep;
    if (id == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if ((id == 0) ? in_ready0 : in_ready1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("accept_wait", ok, 1);
    last_acc = cyc;
    if (ok) begin
      l   = ((len == 0) || (len > 8)) ? 8 : int'(len);
      gap = (id == 0) ? 2 : 0;
      r   = int'(rep);
      for (int c = 0; c <= r; c++) begin
        for (int i = l - 1; i >= 0; i--) begin
          e.data = pat[i];
          e.done = (c == r) && (i == 0);
          e.cyc  = last_acc + 1 + c * (l + gap) + (l - 1 - i);
          if (id == 0) sb0.push_back(e); else sb1.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (id == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
  endtask

  task automatic waitDrain(input int id);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (id == 0 && sb0.size() == 0 && in_ready0) begin ok = 1'b1; break; end
      if (id == 1 && sb1.size() == 0 && in_ready1) begin ok = 1'b1; break; end
    end
    checkOutput("drain", ok, 1);
  endtask

  // Gap instance monitor, plus a 101 detector fed only by qualified bits.
  always @(negedge clk) begin
    checkOutput("done_qual0", done0 & ~out_valid0, 0);
    if (!out_valid0) checkOutput("idle_lvl0", data_out0, 0);
    if (rst && out_valid0) begin
      det_hist = {det_hist[1:0], data_out0};
      det_cnt++;
      if (det_cnt >= 3 && det_hist == 3'b101) det_hits++;
      checkOutput("sb_has_bit0", (sb0.size() > 0), 1);
      if (sb0.size() > 0) begin
        e0 = sb0.pop_front();
        checkOutput("data0", data_out0, e0.data);
        checkOutput("done0", done0, e0.done);
        checkOutput("cycle0", cyc, e0.cyc);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("done_qual1", done1 & ~out_valid1, 0);
    if (!out_valid1) checkOutput("idle_lvl1", data_out1, 0);
    if (rst && out_valid1) begin
      checkOutput("sb_has_bit1", (sb1.size() > 0), 1);
      if (sb1.size() > 0) begin
        e1 = sb1.pop_front();
        checkOutput("data1", data_out1, e1.data);
        checkOutput("done1", done1, e1.done);
        checkOutput("cycle1", cyc, e1.cyc);
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", out_valid0, 0);
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_done", done0, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready0, 1);
    checkOutput("rst_in_ready_b2b", in_ready1, 1);

    // 101 pattern, single copy
    applyStimulus(0, 8'h05, 4'd3, 4'd0);
    waitDrain(0);
    checkOutput("det101_hits", det_hits, 1);

    // Full-width pattern with a stray request pulsed mid-shift
    applyStimulus(0, 8'hA5, 4'd0, 4'd0);
    n = last_acc;
    waitCycle(n + 2);
    pat_in    = 8'hFF;
    in_valid0 = 1'b1;
    checkOutput("ready_low_shift", in_ready0, 0);
    checkOutput("busy_shift", busy0, 1);
    waitCycle(n + 3);
    in_valid0 = 1'b0;
    waitCycle(n + 8);
    checkOutput("ready_low_last", in_ready0, 0);
    waitCycle(n + 9);
    checkOutput("ready_after_last", in_ready0, 1);
    checkOutput("busy_after_last", busy0, 0);

    // Repeats with gaps
    applyStimulus(0, 8'h05, 4'd3, 4'd2);
    n = last_acc;
    waitCycle(n + 4);
    checkOutput("gap_busy", busy0, 1);
    checkOutput("gap_ready", in_ready0, 0);
    waitCycle(n + 12);
    checkOutput("gap_ready_late", in_ready0, 0);
    waitDrain(0);

    // Held request accepted as soon as the previous transfer ends
    applyStimulus(0, 8'h3C, 4'd6, 4'd0);
    applyStimulus(0, 8'hC3, 4'd8, 4'd1);
    waitDrain(0);

    // Length above DATA_W clamps to a full word
    applyStimulus(0, 8'h5A, 4'd12, 4'd1);
    waitDrain(0);

    // Reset at the fourth bit aborts without done
    applyStimulus(0, 8'hA5, 4'd8, 4'd0);
    n = last_acc;
    waitCycle(n + 4);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_data", data_out0, 0);
    checkOutput("abort_valid", out_valid0, 0);
    checkOutput("abort_done", done0, 0);
    checkOutput("abort_busy", busy0, 0);
    sb0.delete();
    sb1.delete();
    waitCycle(n + 6);
    rst = 1'b1;
    waitCycle(n + 7);
    checkOutput("abort_ready", in_ready0, 1);
    applyStimulus(0, 8'h96, 4'd8, 4'd1);
    waitDrain(0);

    // Back-to-back instance: single-bit copies, repeated 101, max repeat count
    applyStimulus(1, 8'h01, 4'd1, 4'd3);
    waitDrain(1);
    applyStimulus(1, 8'h05, 4'd3, 4'd1);
    waitDrain(1);
    applyStimulus(1, 8'h02, 4'd2, 4'd15);
    waitDrain(1);
    applyStimulus(1, 8'h01, 4'd1, 4'd0);
    waitDrain(1);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(k % 2, 8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
      waitDrain(k % 2);
    end

    repeat (3) @(negedge clk);
    checkOutput("sb0_empty", sb0.size(), 0);
    checkOutput("sb1_empty", sb1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
